sum_batch_accumulator: RTL and testbench
========================================

Name: sum_batch_accumulator

Overview:
- Downstream consumer of the parameterized N-bit adder stage.
- Takes the (N+1)-bit sum words over a valid/ready handshake and accumulates BATCH of them into a wider saturating accumulator.
- Presents the batch total on a registered output with its own valid/ready handshake.
- Sits between the adder datapath and any reporting or monitor logic that needs batched totals.

Parameters:
- N, 10, operand width of the upstream adder; input sum is N+1 bits.
- ACC_W, 16, accumulator and result width; must be >= N+1.
- BATCH, 4, number of sums accepted per batch; must be >= 1.
- CNT_W, $clog2(BATCH+1), sample counter width (derived, not overridden).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; begins a new batch when in IDLE.
- in_valid  input  1  upstream sum word valid.
- in_ready  output  1  block accepts in_sum this cycle.
- in_sum  input  N+1  sum word from the adder stage, unsigned.
- out_valid  output  1  batch result available.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  batch total, unsigned, saturated.
- out_ovf  output  1  sticky: saturation occurred during this batch.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, acc=0, count=0.
  - out_valid=0, out_acc=0, out_ovf=0, in_ready=0, busy=0.
  - Reset asserted mid-batch discards all partial data immediately; no output is produced.
- State machine: IDLE, ACCUM, DONE; encoded registers; all outputs are registered or decoded from state only.
- IDLE:
  - in_ready=0.
  - start=1 -> ACCUM next cycle; acc<=0, count<=0, ovf<=0.
  - out_acc keeps its last value.
- ACCUM:
  - in_ready=1.
  - Transfer occurs when in_valid && in_ready.
  - On transfer: acc <= acc + zero_extend(in_sum).
  - Saturation: if the true sum exceeds 2^ACC_W-1, acc <= all-ones and ovf<=1. Once saturated, acc stays all-ones for the rest of the batch.
  - On transfer: count <= count+1.
  - On the transfer where count==BATCH-1:
    - next state DONE.
    - out_acc <= final acc value, including this sum.
    - out_ovf <= final ovf.
    - out_valid <= 1, effective the cycle after the last transfer.
  - in_valid=0 cycles stall with no state change; there is no timeout.
- DONE:
  - in_ready=0.
  - out_valid=1; out_acc and out_ovf are held stable until the handshake completes.
  - out_ready=1 -> out_valid<=0, state<=IDLE next cycle.
- start outside IDLE is ignored; it neither restarts nor queues a batch.
- Latency:
  - Last accepted sum to out_valid: 1 cycle.
  - start to in_ready: 1 cycle.
- Back-to-back batches: IDLE lasts at least 1 cycle between batches. A start asserted in the same cycle as the out_ready handshake is ignored.
- BATCH=1: a single transfer moves ACCUM -> DONE.
- in_sum is sampled only on a transfer; its value is don't-care otherwise.
- out_ovf and out_acc are valid only while out_valid=1. Their values are retained afterwards for debug.

Test Plan:
1. Reset behaviour. Assert rst_n=0 for 3 cycles, then release -> out_valid=0, out_acc=0, out_ovf=0, in_ready=0, busy=0.
2. Basic batch (N=10, ACC_W=16, BATCH=4). Pulse start; feed 100, 200, 300, 400 with in_valid held high; out_ready=1 -> out_valid rises 1 cycle after the 4th transfer, out_acc=1000, out_ovf=0; state returns to IDLE the following cycle.
3. Gaps and backpressure. Feed 2046, 2046, 2046, 2046 with in_valid low for 2 cycles between words; hold out_ready=0 for 5 cycles -> out_acc=8184, out_valid held stable for all 5 cycles, in_ready=0 throughout DONE.
4. Saturation (ACC_W=12). Feed 2046, 2046, 2046, 5 -> out_acc=4095, out_ovf=1; acc stays 4095 after the first overflow.
5. Ignored start. Assert start during ACCUM after 2 transfers -> count is not reset. Finish the batch with 1, 1 after the first two words 10, 20 -> out_acc=32.
6. Reset mid-batch. Apply rst_n=0 after 2 transfers -> all outputs return to reset values asynchronously, with no out_valid. A fresh batch of 1, 2, 3, 4 afterwards -> out_acc=10.

Source files
------------

// File: rtl/sum_batch_accumulator.sv
// Accumulates BATCH unsigned sum words from the adder stage into a saturating
// accumulator and hands the batch total downstream over a valid/ready handshake.
module sum_batch_accumulator #(
  parameter int unsigned N     = 10,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned BATCH = 4,
  parameter int unsigned CNT_W = $clog2(BATCH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:0]       in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  if (ACC_W < N + 1) begin : gen_bad_acc_w
    $error("ACC_W must be at least N+1");
  end
  if (BATCH < 1) begin : gen_bad_batch
    $error("BATCH must be at least 1");
  end

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [CNT_W-1:0] count_q;
  logic [ACC_W-1:0] out_acc_q;
  logic             out_ovf_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             busy_q;

  logic [ACC_W:0]   in_ext;
  logic [ACC_W:0]   sum_full;
  logic             sat;
  logic [ACC_W-1:0] acc_next;
  logic             xfer;
  logic             last;

  // One guard bit above the accumulator catches the carry that signals saturation.
  assign in_ext   = {{(ACC_W - N){1'b0}}, in_sum};
  assign sum_full = {1'b0, acc_q} + in_ext;
  assign sat      = sum_full[ACC_W] | ovf_q;
  assign acc_next = sat ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
  assign xfer     = in_valid & in_ready_q;
  assign last     = (count_q == CNT_W'(BATCH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StAccum;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StAccum: begin
          if (xfer) begin
            acc_q   <= acc_next;
            ovf_q   <= sat;
            count_q <= count_q + CNT_W'(1);
            if (last) begin
              state_q     <= StDone;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_acc_q   <= acc_next;
              out_ovf_q   <= sat;
            end
          end
        end
        StDone: begin
          // start seen here is dropped; IDLE always lasts at least one cycle.
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sum_batch_accumulator.sv
// Drives one stimulus stream into a 16-bit and a 12-bit accumulator in lockstep;
// a monitor checks each presented batch result against a queue of expected totals.
module tb_sum_batch_accumulator;

  localparam int N = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [N:0]  in_sum = '0;

  logic        a_in_ready, a_out_valid, a_out_ovf, a_busy;
  logic [15:0] a_out_acc;
  logic        b_in_ready, b_out_valid, b_out_ovf, b_busy;
  logic [11:0] b_out_acc;

  always #5 clk = ~clk;

  sum_batch_accumulator #(.N(N), .ACC_W(16), .BATCH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_sum(in_sum), .out_valid(a_out_valid), .out_ready(out_ready), .out_acc(a_out_acc),
    .out_ovf(a_out_ovf), .busy(a_busy)
  );

  sum_batch_accumulator #(.N(N), .ACC_W(12), .BATCH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_sum(in_sum), .out_valid(b_out_valid), .out_ready(out_ready), .out_acc(b_out_acc),
    .out_ovf(b_out_ovf), .busy(b_busy)
  );

  typedef struct packed {
    logic [15:0] acc;
    logic        ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Results are checked whenever a DUT presents one; popped on the handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (a_out_valid) begin
        if (qa.size() == 0) chk("a unexpected out_valid", 1, 0);
        else begin
          chk("a out_acc", a_out_acc, qa[0].acc);
          chk("a out_ovf", a_out_ovf, qa[0].ovf);
          chk("a in_ready in DONE", a_in_ready, 0);
          if (out_ready) void'(qa.pop_front());
        end
      end
      if (b_out_valid) begin
        if (qb.size() == 0) chk("b unexpected out_valid", 1, 0);
        else begin
          chk("b out_acc", {4'b0, b_out_acc}, qb[0].acc);
          chk("b out_ovf", b_out_ovf, qb[0].ovf);
          chk("b in_ready in DONE", b_in_ready, 0);
          if (out_ready) void'(qb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic ov, input logic ir, input logic bz);
    chk({name, " a out_valid"}, a_out_valid, ov);
    chk({name, " b out_valid"}, b_out_valid, ov);
    chk({name, " a in_ready"}, a_in_ready, ir);
    chk({name, " b in_ready"}, b_in_ready, ir);
    chk({name, " a busy"}, a_busy, bz);
    chk({name, " b busy"}, b_busy, bz);
  endtask

  task automatic check_cleared(input string name);
    check_outs(name, 1'b0, 1'b0, 1'b0);
    chk({name, " a out_acc"}, a_out_acc, 0);
    chk({name, " b out_acc"}, b_out_acc, 0);
    chk({name, " a out_ovf"}, a_out_ovf, 0);
    chk({name, " b out_ovf"}, b_out_ovf, 0);
  endtask

  task automatic expect_batch(input logic [15:0] a_acc, input logic a_ovf,
                              input logic [15:0] b_acc, input logic b_ovf);
    qa.push_back('{acc: a_acc, ovf: a_ovf});
    qb.push_back('{acc: b_acc, ovf: b_ovf});
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("after start", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic send(input logic [N:0] w, input int gap);
    int n = 0;
    in_valid = 1'b1;
    in_sum   = w;
    while (!a_in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!a_in_ready) chk("in_ready wait timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Called right after the last transfer; optionally stalls out_ready and
  // pulses start on the handshake cycle.
  task automatic wait_done(input int hold, input logic st);
    check_outs("last xfer latency", 1'b1, 1'b0, 1'b1);
    if (hold > 0) out_ready = 1'b0;
    repeat (hold) begin
      tick();
      check_outs("held in DONE", 1'b1, 1'b0, 1'b1);
    end
    out_ready = 1'b1;
    start     = st;
    tick();
    start = 1'b0;
    check_outs("back in IDLE", 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("IDLE holds", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_cleared("reset");

    // Basic batch, in_valid held high, out_ready high.
    out_ready = 1'b1;
    expect_batch(16'd1000, 1'b0, 16'd1000, 1'b0);
    do_start();
    send(100, 0); send(200, 0); send(300, 0); send(400, 0);
    wait_done(0, 1'b0);

    // Gaps of 2 cycles and 5 cycles of backpressure; 12-bit copy saturates.
    expect_batch(16'd8184, 1'b0, 16'd4095, 1'b1);
    do_start();
    send(2046, 2); send(2046, 2); send(2046, 2); send(2046, 0);
    wait_done(5, 1'b0);

    // 12-bit copy saturates on the third word and must stay all-ones after +5.
    expect_batch(16'd6143, 1'b0, 16'd4095, 1'b1);
    do_start();
    send(2046, 0); send(2046, 0); send(2046, 0); send(5, 0);
    wait_done(0, 1'b0);

    // start during ACCUM is ignored; start on the handshake cycle is ignored too.
    expect_batch(16'd32, 1'b0, 16'd32, 1'b0);
    do_start();
    send(10, 0); send(20, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("start in ACCUM", 1'b0, 1'b1, 1'b1);
    send(1, 0); send(1, 0);
    wait_done(2, 1'b1);

    // Reset mid-batch after two transfers: asynchronous clear, no output.
    do_start();
    send(7, 0); send(9, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async reset mid-batch");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_cleared("after mid-batch reset");

    expect_batch(16'd10, 1'b0, 16'd10, 1'b0);
    do_start();
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    wait_done(0, 1'b0);

    tick();
    chk("a results outstanding", qa.size(), 0);
    chk("b results outstanding", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
